// File: rtl/dbu_pkg.sv
// Shared encodings and default sizes for the debug-unit run/step scheduler.
package dbu_pkg;

  localparam int unsigned DFLT_STEP_LIMIT = 16;
  localparam int unsigned DFLT_CNT_W      = 32;

  localparam logic [1:0] HALT_ENC = 2'd0;
  localparam logic [1:0] RUN_ENC  = 2'd1;
  localparam logic [1:0] STEP_ENC = 2'd2;
  localparam logic [1:0] BRK_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_HALT = HALT_ENC,
    ST_RUN  = RUN_ENC,
    ST_STEP = STEP_ENC,
    ST_BRK  = BRK_ENC
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for a raw board input with a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      meta    <= din;
      level   <= meta;
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/dbu_run_ctrl.sv
// Run/step/breakpoint scheduler producing the CPU clock enable, plus display counters.
module dbu_run_ctrl
  import dbu_pkg::*;
#(
  parameter int unsigned STEP_LIMIT = DFLT_STEP_LIMIT,
  parameter int unsigned CNT_W      = DFLT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             step_mode,
  input  logic             brk_en,
  input  logic [31:0]      brk_pc,
  input  logic [31:0]      pc,
  input  logic             ir_write,
  input  logic             clr_cnt,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             brk_hit,
  output logic             step_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned SC_W = $clog2(STEP_LIMIT) + 1;

  logic            run_s;
  logic            run_rise_unused;
  logic            step_s;
  logic            step_p;
  logic            match;
  logic            mask;
  logic            first;
  logic            step_inst;
  logic [SC_W-1:0] step_cnt;
  state_t          st;

  sync_edge u_run_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (run),
    .level (run_s),
    .rise  (run_rise_unused)
  );

  sync_edge u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (step),
    .level (step_s),
    .rise  (step_p)
  );

  assign match = brk_en & ir_write & (pc == brk_pc) & ~mask;
  assign state = st;

  // In instruction-step mode the next fetch after the first cycle is held off.
  always_comb begin
    cpu_ce = 1'b0;
    case (st)
      ST_RUN:  cpu_ce = ~match;
      ST_STEP: cpu_ce = ~step_inst | first | ~ir_write;
      default: cpu_ce = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_HALT;
      brk_hit   <= 1'b0;
      step_err  <= 1'b0;
      mask      <= 1'b0;
      first     <= 1'b0;
      step_inst <= 1'b0;
      step_cnt  <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      // Executing the trapped fetch re-arms the breakpoint.
      if (cpu_ce & ir_write) mask <= 1'b0;

      if (clr_cnt) begin
        cycle_cnt <= '0;
        instr_cnt <= '0;
      end else begin
        if (cpu_ce)            cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (cpu_ce & ir_write) instr_cnt <= instr_cnt + CNT_W'(1);
      end

      case (st)
        ST_HALT: begin
          if (run_s) begin
            st <= ST_RUN;
          end else if (step_p) begin
            st        <= ST_STEP;
            step_inst <= step_mode;
            first     <= 1'b1;
            step_cnt  <= '0;
            step_err  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (match) begin
            st      <= ST_BRK;
            mask    <= 1'b1;
            brk_hit <= 1'b1;
          end else if (!run_s) begin
            st <= ST_HALT;
          end
        end
        ST_BRK: begin
          if (!run_s) begin
            st      <= ST_HALT;
            brk_hit <= 1'b0;
          end
        end
        ST_STEP: begin
          if (!step_inst) begin
            st    <= ST_HALT;
            first <= 1'b0;
          end else if (cpu_ce) begin
            first    <= 1'b0;
            step_cnt <= step_cnt + SC_W'(1);
            if (step_cnt == SC_W'(STEP_LIMIT - 1)) begin
              st       <= ST_HALT;
              step_err <= 1'b1;
            end
          end else begin
            st <= ST_HALT;
          end
        end
        default: st <= ST_HALT;
      endcase
    end
  end

endmodule

// File: doc/dbu_run_ctrl.md
# dbu_run_ctrl

Run/step scheduler for the multi-cycle CPU under the debug unit. It turns the board's run switch and step button into a per-cycle CPU clock enable. Supported modes are free-running, single-cycle step, single-instruction step, and PC breakpoint. It also keeps cycle and instruction counters for display. It sits between the board inputs and the CPU top, and replaces direct gating of the CPU clock.

## Interface
- `STEP_LIMIT`, 16: maximum CPU cycles one instruction-step may consume before it is aborted.
- `CNT_W`, 32: width of the cycle and instruction counters.
- `clk` in 1: system clock (100 MHz board clock); the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: raw level switch; 1 means run freely.
- `step` in 1: raw step button (already debounced off-chip); each rising edge requests one step.
- `step_mode` in 1: 0 selects a cycle step, 1 selects an instruction step. Latched when a step is accepted.
- `brk_en` in 1: enables the breakpoint.
- `brk_pc` in 32: breakpoint address.
- `pc` in 32: current CPU PC.
- `ir_write` in 1: the CPU's IRWrite control; high marks a fetch cycle.
- `clr_cnt` in 1: synchronous clear of both counters.
- `cpu_ce` out 1: CPU clock enable. CPU registers update on an edge only when it is high.
- `state` out 2: controller state (HALT=0, RUN=1, STEP=2, BRK=3).
- `brk_hit` out 1: high while in BRK.
- `step_err` out 1: sticky; set when an instruction step hits `STEP_LIMIT`.
- `cycle_cnt` out CNT_W: count of cycles with `cpu_ce` high.
- `instr_cnt` out CNT_W: count of fetch cycles completed.

## Operation
- **Input synchronisers:** `run` and `step` each pass through a 2-FF synchroniser, giving `run_s` and `step_s`. `step_s` is delayed by one more FF; `step_p = step_s & ~step_d`.
- **Breakpoint match:** `match = brk_en & ir_write & (pc == brk_pc) & ~mask`.
- **HALT:**
  - `cpu_ce` = 0.
  - If `run_s`, go to RUN. `run_s` takes priority over a simultaneous `step_p`.
  - Else if `step_p`, go to STEP, latch `step_mode`, set `first` = 1, clear the step cycle counter.
  - `step_p` in any other state is ignored.
- **RUN:**
  - `cpu_ce = ~match`.
  - On `match`, go to BRK; the fetch at `brk_pc` does not execute.
  - Else if `~run_s`, go to HALT. The enable in that cycle is still 1.
- **BRK:**
  - `cpu_ce` = 0; `mask` is set on entry.
  - If `~run_s`, go to HALT; the user re-raises `run` or steps to resume.
- **`mask`:** cleared on any cycle with `cpu_ce & ir_write`. This makes the breakpoint re-arm after the trapped fetch executes.
- **STEP, cycle mode:** `cpu_ce` = 1 for exactly one cycle, then go to HALT.
- **STEP, instruction mode:**
  - `cpu_ce` = 1 while `first` or `~ir_write`. `first` clears after the first enabled cycle.
  - On the first non-first cycle with `ir_write` = 1, `cpu_ce` = 0 and go to HALT. The CPU is then parked at the next fetch.
  - If the step cycle counter reaches `STEP_LIMIT` enabled cycles, go to HALT and set `step_err`.
  - `step_err` clears only on reset or on the next accepted step.
  - Breakpoints are not checked during STEP.
- **Counters:**
  - `cycle_cnt` += 1 on every `cpu_ce`.
  - `instr_cnt` += 1 on `cpu_ce & ir_write`.
  - Both wrap modulo 2^CNT_W.
  - `clr_cnt` has priority over increment.

## Timing
- **Reset values:** state = HALT, `cpu_ce` = 0, `brk_hit` = 0, `step_err` = 0, counters = 0, `mask` = 0, `first` = 0, all synchroniser FFs = 0. Reset takes effect immediately and asynchronously, including mid-step.
- **Output timing:** `cpu_ce` is combinational from state, `first`, `match` and `ir_write`. All other outputs are registered.
- **Step latency:** `step` is first sampled high at edge k. `step_p` is high during the cycle after edge k+2. STEP is entered at edge k+3. `cpu_ce` is high in the cycle after edge k+3.
- **Run latency:** `run` rising is sampled at edge k; RUN is entered at edge k+2.
- **Step button held:** produces exactly one step.
- **Run raised mid-step:** ignored until STEP returns to HALT.

## Structure
- **Package `dbu_pkg`:** state encoding (HALT/RUN/STEP/BRK as 2-bit localparams), default `STEP_LIMIT`, and `CNT_W`.
- **Sub-module `sync_edge`:** 2-FF synchroniser plus rising-edge detect, with outputs `level` and `rise`. Instantiated twice; the `rise` output of the `run` instance is unused.
- **Main block:** FSM, `mask`/`first` flags, step cycle counter (width clog2(`STEP_LIMIT`)+1), and both counters.

## Test plan
- **Cycle step:** reset, `step_mode`=0, pulse `step` for 5 cycles → exactly one `cpu_ce` cycle 4 cycles after rise; `cycle_cnt`=1; state returns to HALT.
- **Instruction step:** `step_mode`=1, CPU model asserts `ir_write` every 4th cycle starting at the step → `cpu_ce` high 4 cycles, low on the next fetch; `instr_cnt`=1; `cycle_cnt`=4.
- **Breakpoint:** `brk_en`=1, `brk_pc`=0x0000_000C, `run`=1, PC steps 0,4,8,C at fetches → `cpu_ce`=0 in the cycle `pc`=0xC with `ir_write`; `brk_hit`=1; `instr_cnt`=3. Drop and raise `run` → fetch at 0xC executes; `instr_cnt`=4; no re-trap.
- **Step limit:** `step_mode`=1, `ir_write` tied 0 → HALT after 16 enabled cycles; `step_err`=1. Next step clears `step_err`.
- **Priority and wrap:** `run` and `step` rising together → RUN. `clr_cnt` with `cpu_ce`=1 → counters 0. Preload `cycle_cnt`=0xFFFF_FFFF → wraps to 0.
- **Async reset:** assert `rst` mid instruction-step between clock edges → `cpu_ce`=0 and state=HALT immediately; counters 0.
